// File: rtl/lsu_master.sv
// Load/store bus master: turns byte/half/word requests into word-wide memory
// accesses. Sub-word stores use read-modify-write; loads return extended lanes.
module lsu_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WD,
    output logic              WE,
    input  logic [31:0]       RD
);
    localparam int NUM_LANES = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              wr_q;
    logic              uns_q;
    logic              err_q;
    logic [31:0]       buf_q;
    logic [31:0]       rdata_q;

    logic                                misalign;
    logic [31:0]                         load_val;
    logic [31:0]                         lane_b;
    logic [31:0]                         lane_h;
    logic [NUM_LANES-1:0]                be;
    logic [NUM_LANES-1:0][7:0]           wrep;
    logic [NUM_LANES-1:0][7:0]           merged;

    assign misalign = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

    // Lane extraction works straight off RD so rdata updates on the READ edge.
    assign lane_b = RD >> {addr_q[1:0], 3'b000};
    assign lane_h = RD >> {addr_q[1], 4'b0000};

    always_comb begin
        load_val = RD;
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & lane_b[7]}}, lane_b[7:0]};
            2'b01:   load_val = {{16{~uns_q & lane_h[15]}}, lane_h[15:0]};
            default: load_val = RD;
        endcase
    end

    always_comb begin
        be   = 4'b1111;
        wrep = wdata_q;
        case (size_q)
            2'b00: begin
                be   = 4'b0001 << addr_q[1:0];
                wrep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_q;
            end
        endcase
    end

    // Per-lane merge of new store data over the buffered word.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign merged[k] = be[k] ? wrep[k] : buf_q[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    size_q  <= size;
                    wr_q    <= wr;
                    uns_q   <= uns;
                    err_q   <= misalign;
                    if (misalign)                   state <= S_DONE;
                    else if (wr && size == 2'b10)   state <= S_WRITE;
                    else                            state <= S_READ;
                end
                S_READ: begin
                    buf_q <= RD;
                    if (wr_q) state <= S_WRITE;
                    else begin
                        rdata_q <= load_val;
                        state   <= S_DONE;
                    end
                end
                S_WRITE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs decode from state so an async reset drops WE at once.
    assign A     = (state == S_READ || state == S_WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign WE    = (state == S_WRITE);
    assign WD    = (state == S_WRITE) ? merged : 32'h0;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign err   = (state == S_DONE) && err_q;
    assign rdata = rdata_q;
endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master with a word-wide memory model behind the bus.
module tb_lsu_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, WE;
    logic [31:0] rdata, A, WD, RD;

    logic [31:0] mem [256];
    int errors = 0;
    int checks = 0;

    lsu_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .A(A), .WD(WD), .WE(WE), .RD(RD)
    );

    always #5 clk = ~clk;

    assign RD = mem[A[9:2]];
    always @(posedge clk) if (WE) mem[A[9:2]] <= WD;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request, optionally poke req while busy; observe 6 cycles.
    task automatic run(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] ad, input logic [31:0] wd, input bit poke,
                       output int lat, output int we_cnt, output logic [31:0] wd_seen,
                       output logic [31:0] a_seen, output int done_cnt, output logic err_seen);
        lat = 0; we_cnt = 0; wd_seen = '0; a_seen = '0; done_cnt = 0; err_seen = 1'b0;
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; uns = u; addr = ad; wdata = wd;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req = poke; addr = ad ^ 32'h4; wdata = ~wd; uns = ~u;
            end else if (c == 2) req = 1'b0;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = c;
                err_seen = err;
            end
            if (WE) begin
                we_cnt++;
                wd_seen = WD;
                a_seen = A;
            end
        end
    endtask

    int lat, wec, dc;
    logic [31:0] wds, as;
    logic es;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #12;
        chk("rst_A", A, 32'h0);
        chk("rst_WE", {31'b0, WE}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        run(1'b1, 2'b10, 1'b0, 32'd512, 32'h2B345FD4, 1'b0, lat, wec, wds, as, dc, es);
        chk("sw_lat", lat, 2);
        chk("sw_we_cnt", wec, 1);
        chk("sw_A", as, 32'd512);
        chk("sw_WD", wds, 32'h2B345FD4);
        chk("sw_mem", mem[128], 32'h2B345FD4);

        run(1'b0, 2'b10, 1'b0, 32'd512, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lw_lat", lat, 2);
        chk("lw_we_cnt", wec, 0);
        chk("lw_rdata", rdata, 32'h2B345FD4);

        run(1'b0, 2'b00, 1'b1, 32'd513, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lbu_513", rdata, 32'h0000005F);
        run(1'b0, 2'b00, 1'b0, 32'd515, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lb_515", rdata, 32'h0000002B);
        run(1'b0, 2'b01, 1'b0, 32'd514, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lh_514", rdata, 32'h00002B34);
        run(1'b0, 2'b01, 1'b0, 32'd512, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lh_512", rdata, 32'h00005FD4);

        run(1'b1, 2'b00, 1'b0, 32'd514, 32'h000000A3, 1'b0, lat, wec, wds, as, dc, es);
        chk("sb_lat", lat, 3);
        chk("sb_we_cnt", wec, 1);
        chk("sb_WD", wds, 32'h2BA35FD4);
        chk("sb_rdata_kept", rdata, 32'h00005FD4);

        run(1'b0, 2'b00, 1'b0, 32'd514, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lb_514", rdata, 32'hFFFFFFA3);
        run(1'b0, 2'b00, 1'b1, 32'd514, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lbu_514", rdata, 32'h000000A3);

        run(1'b1, 2'b01, 1'b0, 32'd513, 32'h0000BEEF, 1'b0, lat, wec, wds, as, dc, es);
        chk("sh_mis_lat", lat, 1);
        chk("sh_mis_err", {31'b0, es}, 32'h1);
        chk("sh_mis_we", wec, 0);
        chk("sh_mis_mem", mem[128], 32'h2BA35FD4);
        chk("sh_mis_rdata", rdata, 32'h000000A3);

        run(1'b0, 2'b11, 1'b0, 32'd512, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("sz11_err", {31'b0, es}, 32'h1);
        chk("sz11_lat", lat, 1);
        run(1'b0, 2'b10, 1'b0, 32'd514, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("lw_mis_err", {31'b0, es}, 32'h1);
        chk("lw_mis_rdata", rdata, 32'h000000A3);

        // req held during busy must not start a second access
        run(1'b0, 2'b10, 1'b0, 32'd512, 32'h0, 1'b1, lat, wec, wds, as, dc, es);
        chk("poke_done_cnt", dc, 1);
        chk("poke_err", {31'b0, es}, 32'h0);
        chk("poke_rdata", rdata, 32'h2BA35FD4);

        // Reset during the WRITE of a sub-word store
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'd512; wdata = 32'h00000011;
        @(negedge clk); req = 1'b0;   // READ
        @(negedge clk);               // WRITE
        chk("rw_we_before", {31'b0, WE}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rw_we_after", {31'b0, WE}, 32'h0);
        chk("rw_busy_after", {31'b0, busy}, 32'h0);
        dc = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("rw_no_done", dc, 0);
        chk("rw_mem", mem[128], 32'h2BA35FD4);
        chk("rw_rdata_clr", rdata, 32'h0);
        rst_n = 1'b1;

        run(1'b0, 2'b10, 1'b0, 32'd512, 32'h0, 1'b0, lat, wec, wds, as, dc, es);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_rdata", rdata, 32'h2BA35FD4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store bus master for the multi-cycle core. It is the initiator side of the word-wide memory interface (A/WD/WE/RD) served by `memory`.
- It accepts byte, halfword and word load/store requests from the control FSM and performs the word accesses memory needs.
- Sub-word stores are done as read-modify-write.
- Loads return lane-extracted, sign- or zero-extended data.

Parameters:
- ADDR_W, 32, width of request address and memory address bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req  in  1  request strobe from control; sampled only in IDLE.
- wr  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal; sampled with req.
- uns  in  1  1 = zero-extend loads, 0 = sign-extend; sampled with req.
- addr  in  ADDR_W  byte address; sampled with req.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned/illegal flag, valid only while done=1.
- rdata  out  32  load result, held until the next load completes.
- A  out  ADDR_W  memory address, always word-aligned (A[1:0]=00).
- WD  out  32  memory write data.
- WE  out  1  memory write enable.
- RD  in  32  memory read data, combinational from A.

Behaviour:
- Reset: rst_n low asynchronously forces the following.
  - State is IDLE.
  - A=0, WD=0, WE=0, rdata=0, done=0, err=0, busy=0.
  - All request-capture registers are cleared.
- Memory contract:
  - RD is valid in the same cycle A is driven.
  - The write commits on the rising clk edge while WE=1.
- Capture: in IDLE, a rising edge with req=1 latches addr, wdata, size, wr and uns.
  - Inputs may then change freely.
  - req while busy=1 is ignored (not queued).
- Alignment check at acceptance:
  - err when size=11.
  - err when size=01 and addr[0]=1.
  - err when size=10 and addr[1:0]!=00.
- States: IDLE, READ, WRITE, DONE.
- Transitions from IDLE on accepted req:
  - err condition goes to DONE with err=1; no memory access and WE never rises.
  - A load goes to READ.
  - A word store goes to WRITE.
  - A byte/half store goes to READ.
- READ:
  - A = {addr[ADDR_W-1:2],2'b00}, WE=0.
  - RD is registered into an internal word buffer at the end of the cycle.
  - A load then goes to DONE, with rdata updated on that edge.
  - A store then goes to WRITE.
- WRITE:
  - A is the aligned address, WE=1 for exactly one cycle.
  - WD is wdata for a word store, or the buffered word with the selected lane(s) replaced.
  - Goes to DONE.
- DONE:
  - done=1 and err as computed; WE=0.
  - Goes to IDLE unconditionally.
  - A new req is accepted only from IDLE, so back-to-back requests are spaced by at least one idle cycle.
- Latency, with req accepted at the edge ending cycle N:
  - Load or word store: done in cycle N+2.
  - Sub-word store: done in cycle N+3.
  - Error: done in cycle N+1.
- Lanes are little-endian.
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16h+15:16h].
- Load extension:
  - uns=0 replicates the top bit of the selected lane into the upper bits.
  - uns=1 zero-fills the upper bits.
  - Word loads ignore uns.
- Outside READ/WRITE, A, WD and WE idle at 0.
- rdata is unchanged by stores and errors.
- Reset asserted mid-operation:
  - WE deasserts immediately (combinational from state).
  - No pending write commits.
  - done does not pulse.
- The block performs no address-range decode; peripheral/instruction regions are handled by `memory`.

Test Plan:
- Word store 0x2B345FD4 to addr 512, then word load 512 -> WE high exactly one cycle with A=512; done at N+2; rdata=0x2B345FD4.
- After the above: byte load 513 uns=1 -> rdata=0x0000005F. Byte load 515 uns=0 -> 0x0000002B. Half load 514 uns=0 -> 0x00002B34. Half load 512 uns=0 -> 0x00005FD4.
- Byte store wdata=0x000000A3 to 514 -> READ then WRITE with WD=0x2BA35FD4, done at N+3. Then byte load 514 uns=0 -> rdata=0xFFFFFFA3; with uns=1 -> 0x000000A3.
- Half store wdata=0x0000BEEF to 513 -> done at N+1 with err=1; WE never high; memory word 512 unchanged; rdata unchanged.
- size=11, and a word load at 514 -> err=1 each. req pulsed while busy -> ignored; exactly one done per accepted request.
- Sub-word store to 512 with rst_n driven low during WRITE -> WE and busy drop immediately; memory word 512 keeps its previous value; no done pulse; after release a normal load succeeds.
